ship_ctrl: RTL
==============

// Module: ship_ctrl
// PURPOSE
//  Frame-rate controller that schedules the player ship. Turns debounced buttons into
//  paced steps: one immediate step, then auto-repeat. Runs the ship life-cycle state
//  machine (alive / exploding / game over) and the lives count, and issues shot-launch
//  requests. Sits between the button debouncers and the renderer/shot logic.
// PARAMETERS
//  LEFT_LIMIT      0   leftmost ship column
//  RIGHT_LIMIT     19  rightmost ship column
//  RESET_POS       5   spawn column
//  REPEAT_DELAY    8   frame ticks from the first step to the first auto-repeat step (>=1)
//  REPEAT_RATE     3   frame ticks between auto-repeat steps (>=1)
//  EXPLODE_FRAMES  60  frame ticks spent in EXPLODE (>=1)
//  LIVES           3   lives at game start (1..3)
// PORTS
//  clk_36MHz        in   1  system clock
//  reset            in   1  synchronous reset, active-high
//  frame_tick       in   1  one-cycle pulse per video frame
//  game_active      in   1  level; 1 = game running
//  left_debounced   in   1  level, left button
//  right_debounced  in   1  level, right button
//  fire_debounced   in   1  level, fire button
//  hit              in   1  one-cycle pulse, ship struck
//  shot_busy        in   1  level, player shot already in flight
//  ship_x           out  5  ship column, LEFT_LIMIT..RIGHT_LIMIT
//  ship_visible     out  1  1 in ALIVE
//  exploding        out  1  1 in EXPLODE
//  game_over        out  1  1 in OVER
//  lives            out  2  remaining lives
//  moved            out  1  one-cycle pulse when ship_x changes
//  shot_launch      out  1  one-cycle pulse requesting a shot at ship_x
// BEHAVIOUR
//  Reset: state=IDLE, ship_x=RESET_POS, lives=LIVES, all pulses 0, dir_prev=NONE,
//   rpt_cnt=0, fire_prev=0. All outputs are registered.
//  States: IDLE -> ALIVE when game_active=1 (lives:=LIVES, ship_x:=RESET_POS).
//   ALIVE -> EXPLODE on hit (lives:=lives-1, exp_cnt:=EXPLODE_FRAMES-1).
//   EXPLODE: exp_cnt decrements on each frame_tick. On a tick with exp_cnt==0:
//    lives==0 -> OVER; otherwise -> ALIVE with ship_x:=RESET_POS.
//   OVER: holds until game_active=0.
//   game_active=0 in any state -> IDLE on the next cycle. This has priority over all else.
//  Movement is evaluated only in ALIVE, on cycles with frame_tick=1.
//   dir = LEFT if only left=1, RIGHT if only right=1, otherwise NONE (both pressed cancels).
//   dir!=NONE and dir!=dir_prev: step now; rpt_cnt:=REPEAT_DELAY-1.
//   dir==dir_prev!=NONE: if rpt_cnt==0, step and rpt_cnt:=REPEAT_RATE-1;
//    else rpt_cnt:=rpt_cnt-1.
//   dir_prev:=dir on every tick in ALIVE. dir_prev:=NONE whenever not in ALIVE.
//   A step saturates at LEFT_LIMIT / RIGHT_LIMIT. moved=1 only if ship_x actually changed.
//   Button activity between frame ticks is ignored.
//  Fire: on a frame tick in ALIVE with fire_debounced=1, fire_prev=0 and shot_busy=0,
//   shot_launch=1 for one cycle. It pulses in the same cycle as any step; the shot uses
//   the pre-step ship_x. fire_prev:=fire_debounced on each tick; a held button never refires.
//  Simultaneous events: hit with frame_tick in ALIVE -> hit wins; no step, no shot.
//   hit outside ALIVE is ignored. reset overrides everything.
//  Invariant: LEFT_LIMIT <= ship_x <= RIGHT_LIMIT at all times.
// TESTING
//  1 reset, game_active=1, right held from tick 0 -> ship_x 6 at tick 0, 7 at tick 8,
//    8 at tick 11, 9 at tick 14.
//  2 ship_x=19, right held 20 ticks -> ship_x stays 19, moved never pulses; same at 0 with left.
//  3 left+right both held -> no movement; release right -> left steps immediately next tick.
//  4 fire pressed with shot_busy=0 -> one shot_launch; held 10 ticks -> no more;
//    press again with shot_busy=1 -> none.
//  5 hit x3 with defaults -> lives 2,1,0; each EXPLODE lasts 60 ticks then respawns at
//    ship_x=5; after the third hit -> game_over=1; game_active=0 -> IDLE.
//  6 reset mid-EXPLODE, and hit+frame_tick+right in the same cycle -> reset state restored;
//    hit wins with ship_x unchanged.

Source files
------------

// File: rtl/ship_ctrl_if.sv
// Handshake bundle between the button/hit sources and the ship controller.
// The master drives the inputs and observes the ship outputs. The slave is the controller.
interface ship_ctrl_if;
  logic       frame_tick;
  logic       game_active;
  logic       left_debounced;
  logic       right_debounced;
  logic       fire_debounced;
  logic       hit;
  logic       shot_busy;
  logic [4:0] ship_x;
  logic       ship_visible;
  logic       exploding;
  logic       game_over;
  logic [1:0] lives;
  logic       moved;
  logic       shot_launch;

  modport master (
    output frame_tick, game_active, left_debounced, right_debounced,
           fire_debounced, hit, shot_busy,
    input  ship_x, ship_visible, exploding, game_over, lives, moved, shot_launch
  );

  modport slave (
    input  frame_tick, game_active, left_debounced, right_debounced,
           fire_debounced, hit, shot_busy,
    output ship_x, ship_visible, exploding, game_over, lives, moved, shot_launch
  );
endinterface

// File: rtl/ship_ctrl.sv
// Player ship scheduler. It paces button steps with an auto-repeat and runs the
// alive/explode/over life cycle. It also issues edge-triggered shot requests.
module ship_ctrl #(
  parameter int LEFT_LIMIT     = 0,
  parameter int RIGHT_LIMIT    = 19,
  parameter int RESET_POS      = 5,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_RATE    = 3,
  parameter int EXPLODE_FRAMES = 60,
  parameter int LIVES          = 3
) (
  input logic        clk_36MHz,
  input logic        reset,
  ship_ctrl_if.slave bus
);
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int EW = $clog2(EXPLODE_FRAMES + 1);

  localparam logic [4:0]    X_L        = 5'(LEFT_LIMIT);
  localparam logic [4:0]    X_R        = 5'(RIGHT_LIMIT);
  localparam logic [4:0]    X_0        = 5'(RESET_POS);
  localparam logic [1:0]    LIVES0     = 2'(LIVES);
  localparam logic [RW-1:0] RPT_FIRST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT   = RW'(REPEAT_RATE - 1);
  localparam logic [EW-1:0] EXP_INIT   = EW'(EXPLODE_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, ALIVE, EXPLODE, OVER} state_t;
  typedef enum logic [1:0] {D_NONE, D_LEFT, D_RIGHT} dir_t;

  state_t        state;
  dir_t          dir, dir_prev;
  logic [4:0]    ship_x, step_x;
  logic [1:0]    lives;
  logic [RW-1:0] rpt_cnt;
  logic [EW-1:0] exp_cnt;
  logic          fire_prev;
  logic          moved, shot_launch;
  logic          ship_visible, exploding, game_over;

  // Pressing both buttons cancels to NONE. This also restarts the repeat when one is released.
  always_comb begin
    dir = D_NONE;
    if (bus.left_debounced && !bus.right_debounced)      dir = D_LEFT;
    else if (bus.right_debounced && !bus.left_debounced) dir = D_RIGHT;
  end

  always_comb begin
    step_x = ship_x;
    if (dir == D_LEFT && ship_x != X_L)       step_x = ship_x - 5'd1;
    else if (dir == D_RIGHT && ship_x != X_R) step_x = ship_x + 5'd1;
  end

  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      state        <= IDLE;
      ship_x       <= X_0;
      lives        <= LIVES0;
      dir_prev     <= D_NONE;
      rpt_cnt      <= '0;
      exp_cnt      <= '0;
      fire_prev    <= 1'b0;
      moved        <= 1'b0;
      shot_launch  <= 1'b0;
      ship_visible <= 1'b0;
      exploding    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      moved       <= 1'b0;
      shot_launch <= 1'b0;
      if (bus.frame_tick) fire_prev <= bus.fire_debounced;

      if (!bus.game_active) begin
        state        <= IDLE;
        dir_prev     <= D_NONE;
        ship_visible <= 1'b0;
        exploding    <= 1'b0;
        game_over    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state        <= ALIVE;
            lives        <= LIVES0;
            ship_x       <= X_0;
            moved        <= (ship_x != X_0);
            ship_visible <= 1'b1;
          end
          ALIVE: begin
            // A hit on a tick takes priority, so the tick's step and shot are dropped.
            if (bus.hit) begin
              state        <= EXPLODE;
              lives        <= lives - 2'd1;
              exp_cnt      <= EXP_INIT;
              dir_prev     <= D_NONE;
              ship_visible <= 1'b0;
              exploding    <= 1'b1;
            end else if (bus.frame_tick) begin
              dir_prev    <= dir;
              shot_launch <= bus.fire_debounced && !fire_prev && !bus.shot_busy;
              if (dir != D_NONE) begin
                if (dir != dir_prev) begin
                  ship_x  <= step_x;
                  moved   <= (step_x != ship_x);
                  rpt_cnt <= RPT_FIRST;
                end else if (rpt_cnt == '0) begin
                  ship_x  <= step_x;
                  moved   <= (step_x != ship_x);
                  rpt_cnt <= RPT_NEXT;
                end else begin
                  rpt_cnt <= rpt_cnt - 1'b1;
                end
              end
            end
          end
          EXPLODE: begin
            if (bus.frame_tick) begin
              if (exp_cnt == '0) begin
                exploding <= 1'b0;
                if (lives == 2'd0) begin
                  state     <= OVER;
                  game_over <= 1'b1;
                end else begin
                  state        <= ALIVE;
                  ship_visible <= 1'b1;
                  ship_x       <= X_0;
                  moved        <= (ship_x != X_0);
                end
              end else begin
                exp_cnt <= exp_cnt - 1'b1;
              end
            end
          end
          default: ;  // OVER waits for game_active to drop
        endcase
      end
    end
  end

  assign bus.ship_x       = ship_x;
  assign bus.ship_visible = ship_visible;
  assign bus.exploding    = exploding;
  assign bus.game_over    = game_over;
  assign bus.lives        = lives;
  assign bus.moved        = moved;
  assign bus.shot_launch  = shot_launch;
endmodule
